// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with majority-vote bit sampling,
// optional parity, 1 or 2 stop bits and a valid/ready output holding register.
// Runs entirely on clk; a tick enable replaces a derived baud clock.
module uart_rx_frame #(
   parameter int CLKS_PER_TICK = 325,
   parameter int OVERSAMPLE    = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int M   = OVERSAMPLE / 2;
   localparam int TCW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int TIW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);

   localparam logic [TCW-1:0] TICK_LAST = TCW'(CLKS_PER_TICK - 1);
   localparam logic [TIW-1:0] IDX_LO    = TIW'(M - 1);
   localparam logic [TIW-1:0] IDX_MID   = TIW'(M);
   localparam logic [TIW-1:0] IDX_HI    = TIW'(M + 1);
   localparam logic [TIW-1:0] IDX_LAST  = TIW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BITS_ALL  = BCW'(DATA_BITS);
   localparam logic           STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta, rx_s;
   logic [TCW-1:0]       tick_cnt;
   logic                 tick;
   logic [TIW-1:0]       tick_idx;
   logic                 smp_lo, smp_mid;
   logic                 bit_val, resolve, bit_end;
   logic                 armed, start_det, done;
   logic [BCW-1:0]       bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 ferr_acc, perr_acc;

   // Two-of-three vote over the samples taken around mid-bit.
   function automatic logic majority(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // True when data plus received parity bit disagree with the configured sense.
   function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
      logic x;
      x = (^d) ^ p;
      return (PARITY == 1) ? ~x : x;
   endfunction

   // Two-flop synchroniser for the asynchronous pin; idles high like the line
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // Oversample tick divider, realigned to the detected start edge
   always_ff @(posedge clk) begin
      if (!rst || start_det) tick_cnt <= '0;
      else if (tick)         tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + 1'b1;
   end

   // Tick index within the current bit period
   always_ff @(posedge clk) begin
      if (!rst || start_det) tick_idx <= '0;
      else if (tick)         tick_idx <= (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
   end

   assign resolve = tick && (tick_idx == IDX_HI);
   assign bit_end = tick && (tick_idx == IDX_LAST);
   // Third vote is the live synchronised line at tick M+1
   assign bit_val = majority(smp_lo, smp_mid, rx_s);

   // Capture the two early votes of each bit
   always_ff @(posedge clk) begin
      if (tick && (tick_idx == IDX_LO))  smp_lo  <= rx_s;
      if (tick && (tick_idx == IDX_MID)) smp_mid <= rx_s;
   end

   // Frame state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state decode plus start-detect and frame-completion strobes
   always_comb begin
      state_d   = state_q;
      start_det = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (armed && !rx_s) begin
               state_d   = S_START;
               start_det = 1'b1;
            end
         end
         S_START: begin
            if (resolve && bit_val) state_d = S_IDLE;
            else if (bit_end)       state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end && (bit_cnt == BITS_ALL))
               state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            // Finish at the last stop vote so the next start edge is not missed
            if (resolve && (stop_cnt == STOP_LAST)) begin
               state_d = S_IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);

   // Per-frame control: arming, bit/stop counters and error accumulators
   always_ff @(posedge clk) begin
      if (!rst) begin
         armed    <= 1'b0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         ferr_acc <= 1'b0;
         perr_acc <= 1'b0;
      end else begin
         if (start_det) begin
            armed    <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
         end else if (done) begin
            // A line still low at the final vote must go high before re-arming
            armed <= rx_s;
         end else if ((state_q == S_IDLE) && rx_s) begin
            armed <= 1'b1;
         end
         if (resolve) begin
            if (state_q == S_DATA)               bit_cnt  <= bit_cnt + 1'b1;
            if (state_q == S_PARITY)             perr_acc <= parity_fail(shreg, bit_val);
            if ((state_q == S_STOP) && !bit_val) ferr_acc <= 1'b1;
         end
         if (bit_end && (state_q == S_STOP)) stop_cnt <= 1'b1;
      end
   end

   // Data shift register, LSB arrives first
   always_ff @(posedge clk) begin
      if (resolve && (state_q == S_DATA))
         shreg <= {bit_val, shreg[DATA_BITS-1:1]};
   end

   // Output holding register with valid/ready handshake and overrun pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done && (!data_valid || data_ready)) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
            frame_err  <= ferr_acc | ~bit_val;
            parity_err <= perr_acc;
         end else if (done) begin
            overrun <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver with oversampling and majority-vote bit sampling. Supports configurable data width, optional odd/even parity and 1 or 2 stop bits. Reports framing, parity and overrun errors, and presents each received word on a valid/ready output handshake. Runs entirely in the system clock domain, using a tick enable instead of a derived clock. Sits between the board RX pin and the host-side command/CPU interface.

Parameters:
CLKS_PER_TICK, 325, clk cycles per oversample tick (50 MHz / (9600*16)); must be >= 2
OVERSAMPLE, 16, ticks per bit period; even, >= 8
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
rx  in  1  asynchronous serial line; idle high
data_out  out  DATA_BITS  received word, LSB = first data bit on the line
data_valid  out  1  data_out/err flags valid; held until accepted
data_ready  in  1  consumer accepts the word when data_valid && data_ready at posedge clk
frame_err  out  1  a stop bit sampled 0; qualified by data_valid
parity_err  out  1  parity mismatch; qualified by data_valid; always 0 when PARITY=0
overrun  out  1  one-cycle pulse: a completed frame was dropped because the output was still full
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst sampled low at posedge clk forces state IDLE, tick counter 0, data_valid=0, data_out=0, frame_err=0, parity_err=0, overrun=0, busy=0. Reset is honoured mid-frame; the partial frame is discarded.
- rx passes through a 2-flop synchroniser (rx_s) initialised to 1. All decisions use rx_s. This adds 2 clk of latency.
- Tick generator: a counter over 0..CLKS_PER_TICK-1 emits a 1-clk tick on wrap. It is cleared on start detection, so sample phase is aligned to the start edge.
- Within each bit, a tick index 0..OVERSAMPLE-1 is kept. Samples are taken at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three samples and is resolved at tick M+1. The bit ends after tick OVERSAMPLE-1.
- States:
  - IDLE -> START: requires rx_s=0 while the armed flag is set. Armed sets when rx_s=1 is seen in IDLE, so a held-low line (break) does not retrigger.
  - START -> IDLE: if the majority value is 1 (false start, glitch), return to IDLE with no output and no flags.
  - START -> DATA: if the majority value is 0, proceed at end of bit.
  - DATA: shift in DATA_BITS majority bits, LSB first. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: one bit. Odd parity: the XOR of data and parity bit must be 1. Even parity: it must be 0. A mismatch sets parity_err.
  - STOP: STOP_BITS bits; any majority-0 sets frame_err. Completion occurs at tick M+1 of the last stop bit, not end of bit, so the receiver can resync early. The machine then enters IDLE with armed = (last sample = 1).
- Completion with output empty (data_valid=0), or being accepted in the same cycle: the next cycle loads data_out, frame_err and parity_err, and sets data_valid=1. Latency is 1 clk after resolution of the final stop sample.
- Completion with data_valid=1 and data_ready=0: the new frame is dropped, overrun pulses high for 1 clk, and existing output is unchanged.
- Accept without a new completion: data_valid clears the next cycle. data_out holds its old value; the error flags clear.
- Frames with a framing error are still delivered, with frame_err=1.
- Width rules: the internal shift register is DATA_BITS wide. The bit counter is ceil(log2(DATA_BITS+1)) bits, and the tick index is ceil(log2(OVERSAMPLE)) bits.

Test Plan:
(Sim params: CLKS_PER_TICK=4, OVERSAMPLE=16, i.e. 64 clk/bit.)
1. DATA_BITS=8, PARITY=0, send 0xA5 with data_ready=1 -> data_valid high for exactly 1 clk, data_out=0xA5, frame_err=0, parity_err=0, busy falls at completion.
2. PARITY=2 (even): send 0x03 with parity bit 0 -> parity_err=0. Send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1.
3. Send 0x5A with stop bit forced 0 -> data_out=0x5A, frame_err=1. Then hold rx low 20 bit times -> no further data_valid until rx returns high and a new start arrives.
4. 20-clk low glitch on the idle line -> no data_valid and no flags. A full frame 0x3C sent immediately after -> data_out=0x3C. Also: 1-tick glitches inside data bits are rejected by the majority vote.
5. data_ready=0: send 0x11 then 0x22 -> data_out stays 0x11 and overrun pulses once at completion of 0x22. Raising data_ready then gives one accept of 0x11 and no 0x22.
6. Assert rst low for 1 clk in the middle of data bit 4 -> busy=0 and data_valid=0 next cycle. A following frame 0x7E is received correctly. Repeat with DATA_BITS=7, STOP_BITS=2, PARITY=1 sending 0x41 -> data_out=0x41, no errors.
